// File: rtl/imgproc_frame_ctrl.sv
// rtl/imgproc_frame_ctrl.sv - frame sequencer: sof/eof tracking, switch debounce, prime gating, drain flush
// Optional FRAME_STATS_EN adds per-frame pixel count and sticky truncated-frame flag.
module imgproc_frame_ctrl #(
    parameter int IMG_W        = 640,
    parameter int IMG_H        = 480,
    parameter int PRIME_ROWS   = 2,
    parameter int FLUSH_CYCLES = 4,
    parameter int DB_CYCLES    = 16,
    parameter int CNT_W        = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iDVAL,
    input  logic [15:0]      iX_Cont,
    input  logic [15:0]      iY_Cont,
    input  logic             iSW,
    output logic             oMODE,
    output logic             oOUT_EN,
    output logic             oFRAME_START,
    output logic             oFRAME_DONE,
    output logic [CNT_W-1:0] oFRAME_CNT,
    output logic             oBUSY
`ifdef FRAME_STATS_EN
    ,
    output logic [31:0]      oPIX_CNT,
    output logic             oERR_SHORT
`endif
);

    localparam int FW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int DBW = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_ACTIVE, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic             mode_q, mode_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             sw_meta_q, sw_sync_q, sw_db_q;
    logic [DBW-1:0]   db_cnt_q;
    logic             sof, eof, accept_sof, truncated;

    assign sof = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
    assign eof = iDVAL && (iX_Cont == 16'(IMG_W - 1)) && (iY_Cont == 16'(IMG_H - 1));

    // Switch must disagree with the debounced value for DB_CYCLES samples in a row.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sw_meta_q <= 1'b0;
            sw_sync_q <= 1'b0;
            sw_db_q   <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            sw_meta_q <= iSW;
            sw_sync_q <= sw_meta_q;
            if (sw_sync_q != sw_db_q) begin
                if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
                    sw_db_q  <= sw_sync_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            mode_q      <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        mode_d      = mode_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        accept_sof  = 1'b0;
        truncated   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sof) accept_sof = 1'b1;
            end
            S_PRIME: begin
                if (sof) begin
                    accept_sof = 1'b1;
                    truncated  = 1'b1;
                end else if (eof) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FW'(FLUSH_CYCLES - 1);
                end else if (iDVAL && (iY_Cont >= 16'(PRIME_ROWS))) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (sof) begin
                    accept_sof = 1'b1;
                    truncated  = 1'b1;
                end else if (eof) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FW'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                // A new frame arriving mid-drain still completes the old one.
                if (sof || (flush_cnt_q == '0)) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = S_IDLE;
                    accept_sof  = sof;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept_sof) begin
            state_d = S_PRIME;
            start_d = 1'b1;
            mode_d  = sw_db_q;
        end
    end

    assign oMODE        = mode_q;
    assign oOUT_EN      = (state_q == S_ACTIVE) || (state_q == S_FLUSH);
    assign oFRAME_START = start_q;
    assign oFRAME_DONE  = done_q;
    assign oFRAME_CNT   = frame_cnt_q;
    assign oBUSY        = (state_q != S_IDLE);

`ifdef FRAME_STATS_EN
    logic [31:0] pix_cnt_q;
    logic        err_short_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pix_cnt_q   <= '0;
            err_short_q <= 1'b0;
        end else begin
            if (sof) begin
                pix_cnt_q <= 32'd1;
            end else if (iDVAL && (state_q != S_IDLE)) begin
                pix_cnt_q <= pix_cnt_q + 32'd1;
            end
            if (truncated) err_short_q <= 1'b1;
        end
    end

    assign oPIX_CNT   = pix_cnt_q;
    assign oERR_SHORT = err_short_q;
`endif

endmodule

// File: tb/tb_imgproc_frame_ctrl.sv
// tb/tb_imgproc_frame_ctrl.sv - directed self-checking bench for imgproc_frame_ctrl (8x6 frames)
module tb_imgproc_frame_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NP = W * H;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iDVAL;
    logic [15:0] iX_Cont;
    logic [15:0] iY_Cont;
    logic        iSW;
    logic        oMODE, oOUT_EN, oFRAME_START, oFRAME_DONE, oBUSY;
    logic [7:0]  oFRAME_CNT;
`ifdef FRAME_STATS_EN
    logic [31:0] oPIX_CNT;
    logic        oERR_SHORT;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt  = 8'd0;
    logic       exp_mode = 1'b0;
    logic       exp_err  = 1'b0;

    imgproc_frame_ctrl #(
        .IMG_W(W), .IMG_H(H), .PRIME_ROWS(2), .FLUSH_CYCLES(4), .DB_CYCLES(4), .CNT_W(8)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iSW(iSW), .oMODE(oMODE), .oOUT_EN(oOUT_EN), .oFRAME_START(oFRAME_START),
        .oFRAME_DONE(oFRAME_DONE), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
`ifdef FRAME_STATS_EN
        , .oPIX_CNT(oPIX_CNT), .oERR_SHORT(oERR_SHORT)
`endif
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic pix(input int i);
        iDVAL   = 1'b1;
        iX_Cont = 16'(i % W);
        iY_Cont = 16'(i / W);
        tick();
    endtask

    task automatic idle(input int n);
        iDVAL = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Pixels from..to of a frame entered from IDLE/PRIME/ACTIVE (never from FLUSH).
    task automatic pixels(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            pix(i);
            check("out_en", 32'(oOUT_EN), 32'((i / W) >= 2));
            check("start",  32'(oFRAME_START), 32'(i == 0));
            check("done",   32'(oFRAME_DONE), 32'd0);
            check("mode",   32'(oMODE), 32'(exp_mode));
            check("busy",   32'(oBUSY), 32'd1);
        end
    endtask

    task automatic finish_frame();
        iDVAL = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_out_en", 32'(oOUT_EN), 32'd1);
            check("flush_done",   32'(oFRAME_DONE), 32'd0);
        end
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("drain_out_en", 32'(oOUT_EN), 32'd0);
        check("drain_done",   32'(oFRAME_DONE), 32'd1);
        check("drain_cnt",    32'(oFRAME_CNT), 32'(exp_cnt));
        check("drain_busy",   32'(oBUSY), 32'd0);
`ifdef FRAME_STATS_EN
        check("pix_cnt", oPIX_CNT, 32'd48);
`endif
        tick();
        check("done_pulse_end", 32'(oFRAME_DONE), 32'd0);
    endtask

    initial begin
        iRST = 1'b1; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0; iSW = 1'b0;
        tick(); tick();
        iRST = 1'b0;
        check("rst_busy",   32'(oBUSY), 32'd0);
        check("rst_out_en", 32'(oOUT_EN), 32'd0);
        check("rst_mode",   32'(oMODE), 32'd0);
        check("rst_cnt",    32'(oFRAME_CNT), 32'd0);
        check("rst_start",  32'(oFRAME_START), 32'd0);
        check("rst_done",   32'(oFRAME_DONE), 32'd0);

        // Clean frame
        pixels(0, NP - 1);
        finish_frame();

        // 3-cycle glitch on the switch must be rejected
        iSW = 1'b1; idle(3);
        iSW = 1'b0; idle(6);
        pixels(0, NP - 1);
        finish_frame();

        // Switch change during a frame only lands at the following sof
        iSW = 1'b1;
        pixels(0, NP - 1);
        finish_frame();
        exp_mode = 1'b1;
        pixels(0, NP - 1);
        finish_frame();

        // Truncated frame: sof arrives at row 3
        pixels(0, 3 * W - 1);
        pixels(0, 0);
        check("trunc_cnt",   32'(oFRAME_CNT), 32'(exp_cnt));
        check("trunc_out_en", 32'(oOUT_EN), 32'd0);
`ifdef FRAME_STATS_EN
        exp_err = 1'b1;
        check("err_short", 32'(oERR_SHORT), 32'(exp_err));
        check("trunc_pix", oPIX_CNT, 32'd1);
`endif
        pixels(1, NP - 1);
        // sof during the 2nd FLUSH cycle
        idle(1);
        check("flush2_out_en", 32'(oOUT_EN), 32'd1);
        pix(0);
        exp_cnt = exp_cnt + 8'd1;
        check("ovl_done",   32'(oFRAME_DONE), 32'd1);
        check("ovl_start",  32'(oFRAME_START), 32'd1);
        check("ovl_cnt",    32'(oFRAME_CNT), 32'(exp_cnt));
        check("ovl_busy",   32'(oBUSY), 32'd1);
        check("ovl_out_en", 32'(oOUT_EN), 32'd0);
        pixels(1, NP - 1);
        finish_frame();

        // Reset in ACTIVE
        pixels(0, 20);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        exp_cnt = 8'd0; exp_mode = 1'b0; exp_err = 1'b0;
        check("mrst_busy",   32'(oBUSY), 32'd0);
        check("mrst_out_en", 32'(oOUT_EN), 32'd0);
        check("mrst_mode",   32'(oMODE), 32'd0);
        check("mrst_cnt",    32'(oFRAME_CNT), 32'd0);
        check("mrst_done",   32'(oFRAME_DONE), 32'd0);
        check("mrst_start",  32'(oFRAME_START), 32'd0);
`ifdef FRAME_STATS_EN
        check("mrst_err", 32'(oERR_SHORT), 32'(exp_err));
`endif
        // iSW still high: re-debounced to 1 before the next frame
        idle(8);
        exp_mode = 1'b1;
        pixels(0, NP - 1);
        finish_frame();

        // 256 frames: counter wraps 255 -> 0 and returns to its start value
        iSW = 1'b0;
        idle(8);
        exp_mode = 1'b0;
        for (int f = 0; f < 256; f++) begin
            pixels(0, NP - 1);
            finish_frame();
        end
        check("wrap_cnt", 32'(oFRAME_CNT), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
